// File: rtl/nes_host_cmd_queue_if.sv
// Host slave port and core command port of the NES host command queue.
// slave is the queue's view of the bus; master is the host/core side.
interface nes_host_cmd_queue_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [15:0] address;
  logic [15:0] writedata;
  logic [7:0]  readdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_addr;

  modport slave (
    input  chipselect, write, read, address, writedata, cmd_ready,
    output readdata, cmd_valid, cmd_op, cmd_data, cmd_addr
  );

  modport master (
    output chipselect, write, read, address, writedata, cmd_ready,
    input  readdata, cmd_valid, cmd_op, cmd_data, cmd_addr
  );
endinterface

// File: rtl/nes_host_cmd_queue.sv
// Show-ahead command FIFO from the HPS bridge to the NES core, with flush on RESET_CPU and a status byte.
// Define NES_CMDQ_STATS_EN to add a saturating drop counter readable at address[0]==1.
module nes_host_cmd_queue #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  nes_host_cmd_queue_if.slave bus
);

  localparam logic [7:0]     OP_RESET_CPU = 8'h00;
  localparam logic [PTR_W:0] FULL_COUNT   = (PTR_W+1)'(DEPTH);

  // Each entry is {op, data, addr}.
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       readdata_q, readdata_d;

  logic        push, pop, flush, accept, drop, wr_en;
  logic        full, empty;
  logic        status_rd, stats_rd;
  logic [7:0]  status;
  logic [31:0] head;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign push      = bus.chipselect & bus.write;
  assign pop       = ~empty & bus.cmd_ready;
  assign flush     = push & (bus.writedata[15:8] == OP_RESET_CPU);
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop & ~flush;
  assign wr_en     = flush | accept;
  assign status_rd = bus.chipselect & bus.read & ~bus.address[0];
  assign stats_rd  = bus.chipselect & bus.read &  bus.address[0];
  assign status    = {overflow_q, full, empty, 5'(count_q)};

  // A flush restarts the queue at the slot being written, so it works even when full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = (PTR_W+1)'(1);
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {bus.writedata, bus.address};
  end

`ifdef NES_CMDQ_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d, drop_base;

  // A read clears the counter first so a same-cycle drop is still counted.
  always_comb begin
    drop_base  = stats_rd ? 8'h00 : drop_cnt_q;
    drop_cnt_d = drop_base;
    if (drop && (drop_base != 8'hFF)) drop_cnt_d = drop_base + 8'h01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= 8'h00;
    else       drop_cnt_q <= drop_cnt_d;
  end
`endif

  always_comb begin
    overflow_d = (overflow_q & ~status_rd) | drop;
    readdata_d = readdata_q;
    if (status_rd) begin
      readdata_d = status;
    end else if (stats_rd) begin
`ifdef NES_CMDQ_STATS_EN
      readdata_d = drop_cnt_q;
`else
      readdata_d = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      readdata_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      readdata_q <= readdata_d;
    end
  end

  // Head fields are forced to zero when empty so reset never exposes stale RAM.
  assign head          = mem_q[rd_ptr_q];
  assign bus.cmd_valid = ~empty;
  assign bus.cmd_op    = empty ? 8'h00  : head[31:24];
  assign bus.cmd_data  = empty ? 8'h00  : head[23:16];
  assign bus.cmd_addr  = empty ? 16'h0000 : head[15:0];
  assign bus.readdata  = readdata_q;

endmodule

// File: tb/tb_nes_host_cmd_queue.sv
// Self-checking bench for nes_host_cmd_queue: queue-based reference model plus directed literal checks.
// Stats expectations follow NES_CMDQ_STATS_EN when the bench is built with the same macro.
module tb_nes_host_cmd_queue;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nes_host_cmd_queue_if bus();

  nes_host_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] mq[$];
  logic        mOv;
  logic [7:0]  mRd;
  int          mDrops;
  bit          mPush, mPop, mRead, mFlush, mDrop;
  int          mSize;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated from the bus rules on each rising edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mOv    = 1'b0;
      mRd    = 8'h00;
      mDrops = 0;
    end else begin
      mSize  = mq.size();
      mPush  = bus.chipselect && bus.write;
      mRead  = bus.chipselect && bus.read;
      mPop   = (mSize > 0) && bus.cmd_ready;
      mFlush = mPush && (bus.writedata[15:8] == 8'h00);
      mDrop  = mPush && !mFlush && (mSize == DEPTH) && !mPop;
      if (mRead) begin
        if (!bus.address[0]) mRd = {mOv, mSize == DEPTH, mSize == 0, 5'(mSize)};
`ifdef NES_CMDQ_STATS_EN
        else mRd = 8'(mDrops);
`else
        else mRd = 8'h00;
`endif
      end
      if (mRead && !bus.address[0]) mOv = 1'b0;
      if (mRead &&  bus.address[0]) mDrops = 0;
      if (mDrop) begin
        mOv = 1'b1;
        if (mDrops < 255) mDrops++;
      end
      if (mFlush) begin
        mq.delete();
        mq.push_back({bus.writedata, bus.address});
      end else begin
        if (mPop) void'(mq.pop_front());
        if (mPush && !mDrop) mq.push_back({bus.writedata, bus.address});
      end
    end
  end

  // Compare DUT outputs against the model every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("cmd_valid", bus.cmd_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        checkOutput("cmd_op",   bus.cmd_op,   mq[0][31:24]);
        checkOutput("cmd_data", bus.cmd_data, mq[0][23:16]);
        checkOutput("cmd_addr", bus.cmd_addr, mq[0][15:0]);
      end
      checkOutput("readdata", bus.readdata, mRd);
    end
  end

  task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic ready);
    bus.chipselect = cs;
    bus.write      = wr;
    bus.read       = rd;
    bus.address    = addr;
    bus.writedata  = wdata;
    bus.cmd_ready  = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic pushCmd(input logic [7:0] op, input logic [7:0] data,
                         input logic [15:0] addr, input logic ready);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, {op, data}, ready);
  endtask

  task automatic readReg(input logic sel);
    applyStimulus(1'b1, 1'b0, 1'b1, {15'h0000, sel}, 16'h0000, 1'b0);
  endtask

  task automatic idle(input logic ready);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, ready);
  endtask

  logic [7:0] expStats;

  initial begin
    reset          = 1'b1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 16'h0000;
    bus.writedata  = 16'h0000;
    bus.cmd_ready  = 1'b0;
    #2;
    checkOutput("reset cmd_valid", bus.cmd_valid, 1'b0);
    checkOutput("reset readdata",  bus.readdata,  8'h00);
    checkOutput("reset cmd_op",    bus.cmd_op,    8'h00);
    checkOutput("reset cmd_data",  bus.cmd_data,  8'h00);
    checkOutput("reset cmd_addr",  bus.cmd_addr,  16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single push, held head, pop, empty status.
    pushCmd(8'h03, 8'hA9, 16'h8000, 1'b0);
    checkOutput("t1 cmd_valid", bus.cmd_valid, 1'b1);
    checkOutput("t1 cmd_op",    bus.cmd_op,    8'h03);
    checkOutput("t1 cmd_data",  bus.cmd_data,  8'hA9);
    checkOutput("t1 cmd_addr",  bus.cmd_addr,  16'h8000);
    repeat (5) idle(1'b0);
    checkOutput("t1 held cmd_addr", bus.cmd_addr, 16'h8000);
    idle(1'b1);
    checkOutput("t1 popped", bus.cmd_valid, 1'b0);
    readReg(1'b0);
    checkOutput("t1 status", bus.readdata, 8'h20);

    // Fill, overflow, sticky flag cleared by read.
    for (int i = 0; i < DEPTH; i++) pushCmd(8'h03, 8'(i), 16'h0100 + 16'(i), 1'b0);
    pushCmd(8'h03, 8'hEE, 16'hDEAD, 1'b0);
    readReg(1'b0);
    checkOutput("t2 status overflow", bus.readdata, 8'hD0);
    readReg(1'b0);
    checkOutput("t2 status cleared", bus.readdata, 8'h50);

    // Push and pop while full.
    pushCmd(8'h03, 8'h77, 16'h1234, 1'b1);
    readReg(1'b0);
    checkOutput("t3 status full", bus.readdata, 8'h50);
    checkOutput("t3 head after pop", bus.cmd_data, 8'h01);
    repeat (DEPTH - 1) idle(1'b1);
    checkOutput("t3 tail data", bus.cmd_data, 8'h77);
    checkOutput("t3 tail addr", bus.cmd_addr, 16'h1234);
    idle(1'b1);
    checkOutput("t3 drained", bus.cmd_valid, 1'b0);

    // Flush via RESET_CPU.
    for (int i = 0; i < 5; i++) pushCmd(8'h03, 8'h40 + 8'(i), 16'h2000 + 16'(i), 1'b0);
    pushCmd(8'h00, 8'h5A, 16'h0042, 1'b0);
    checkOutput("t4 cmd_op",   bus.cmd_op,   8'h00);
    checkOutput("t4 cmd_data", bus.cmd_data, 8'h5A);
    readReg(1'b0);
    checkOutput("t4 status count1", bus.readdata, 8'h01);
    idle(1'b1);
    checkOutput("t4 only reset drains", bus.cmd_valid, 1'b0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 10; i++) pushCmd(8'h03, 8'(i), 16'h3000 + 16'(i), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5 async cmd_valid", bus.cmd_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    readReg(1'b0);
    checkOutput("t5 status after reset", bus.readdata, 8'h20);

    // Drop counter saturation and clear-on-read.
    for (int i = 0; i < DEPTH; i++) pushCmd(8'h03, 8'(i), 16'h4000 + 16'(i), 1'b0);
    for (int i = 0; i < 300; i++) pushCmd(8'h03, 8'(i), 16'h5000, 1'b0);
`ifdef NES_CMDQ_STATS_EN
    expStats = 8'hFF;
`else
    expStats = 8'h00;
`endif
    readReg(1'b1);
    checkOutput("t6 stats saturated", bus.readdata, expStats);
    readReg(1'b1);
    checkOutput("t6 stats cleared", bus.readdata, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0001, {8'h03, 8'h11}, 1'b0);
    checkOutput("t6 stats read with drop", bus.readdata, 8'h00);
`ifdef NES_CMDQ_STATS_EN
    expStats = 8'h01;
`else
    expStats = 8'h00;
`endif
    readReg(1'b1);
    checkOutput("t6 stats after same-cycle drop", bus.readdata, expStats);
    readReg(1'b0);
    checkOutput("t6 status overflow", bus.readdata, 8'hD0);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
